pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/IX, IX/IM, IM/WB).
- Latches one generic data bus and one control bus per stage.
- Adds a valid/ready handshake, a 2-entry skid buffer for back-pressure, flush with bubble insertion, and a saturating stall counter.
- Instantiated between any two processor stages; replaces per-stage hand-written latch modules.

---
 rtl/pipe_stage_reg_if.sv | 27 ++
 rtl/pipe_stage_reg.sv | 129 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages.
// The upstream and downstream sides of one stage register share this bundle.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  // Environment side: drives the upstream request and the downstream accept.
  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  // Stage register side.
  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with a 2-entry skid buffer, flush with
// bubble insertion and a saturating back-pressure counter. State moves on negedge clk.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W      = 96,
  parameter int unsigned        CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter int unsigned        CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                stall_cnt_clr,
  pipe_stage_reg_if.slave     bus,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic              valid_q, valid_n;
  logic [DATA_W-1:0] main_data_q, main_data_n;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_n;
  logic [DATA_W-1:0] skid_data_q, skid_data_n;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_n;
  logic [CNT_W-1:0]  stall_q, stall_n;
  logic              in_ready_c;
  logic              in_xfer;
  logic              out_xfer;

  // State and datapath registers.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      valid_q     <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_n;
      valid_q     <= valid_n;
      main_data_q <= main_data_n;
      main_ctrl_q <= main_ctrl_n;
      skid_data_q <= skid_data_n;
      skid_ctrl_q <= skid_ctrl_n;
      stall_q     <= stall_n;
    end
  end

  // Next-state, entry movement and stall counter.
  always_comb begin
    in_ready_c  = (state_q != TWO);
    in_xfer     = bus.in_valid & in_ready_c;
    out_xfer    = valid_q & bus.out_ready;
    state_n     = state_q;
    valid_n     = valid_q;
    main_data_n = main_data_q;
    main_ctrl_n = main_ctrl_q;
    skid_data_n = skid_data_q;
    skid_ctrl_n = skid_ctrl_q;
    stall_n     = stall_q;

    if (flush) begin
      // Bubble insertion; any concurrent input is dropped, main data goes stale.
      state_n     = EMPTY;
      valid_n     = 1'b0;
      main_ctrl_n = CTRL_BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_n     = ONE;
            valid_n     = 1'b1;
            main_data_n = bus.in_data;
            main_ctrl_n = bus.in_ctrl;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_data_n = bus.in_data;
            main_ctrl_n = bus.in_ctrl;
          end else if (out_xfer) begin
            state_n     = EMPTY;
            valid_n     = 1'b0;
            main_ctrl_n = CTRL_BUBBLE;
          end else if (in_xfer) begin
            state_n     = TWO;
            skid_data_n = bus.in_data;
            skid_ctrl_n = bus.in_ctrl;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_n     = ONE;
            main_data_n = skid_data_q;
            main_ctrl_n = skid_ctrl_q;
          end
        end
        default: begin
          state_n     = EMPTY;
          valid_n     = 1'b0;
          main_ctrl_n = CTRL_BUBBLE;
        end
      endcase
    end

    if (stall_cnt_clr) begin
      stall_n = '0;
    end else if (valid_q && !bus.out_ready && !flush && (stall_q != CNT_MAX)) begin
      stall_n = stall_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign occupancy     = state_q;
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, back-pressure, flush,
// counter saturation and bubble control.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 96;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CNT_W  = 4;

  logic clk = 1'b1;
  logic rst;
  logic flush;
  logic stall_cnt_clr;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  pipe_stage_reg #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(16'h0000), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_cnt_clr(stall_cnt_clr),
    .bus(bus), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance past one active (negative) edge; outputs are then stable.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic v, input int unsigned d, input logic [15:0] c);
    bus.in_valid = v;
    bus.in_data  = DATA_W'(d);
    bus.in_ctrl  = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall_cnt_clr = 1'b0; bus.out_ready = 1'b0;
    send(1'b0, 0, 16'h0);
    step(); step();
    rst = 1'b0;
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_data !== '0) $display("FAIL reset_data got %0h want 0", bus.out_data); else n_pass++;
    n_total++; if (bus.out_ctrl !== 16'h0000) $display("FAIL reset_ctrl got %0h want 0", bus.out_ctrl); else n_pass++;
    n_total++; if (occupancy !== 2'd0) $display("FAIL reset_occ got %0d want 0", occupancy); else n_pass++;
    n_total++; if (stall_cnt !== 4'd0) $display("FAIL reset_stall got %0d want 0", stall_cnt); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    send(1'b1, 32'hA1, 16'h00A1); step();
    send(1'b1, 32'hB2, 16'h00B2); step();
    n_total++; if (occupancy !== 2'd2) $display("FAIL mid_fill_occ got %0d want 2", occupancy); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_valid got %0b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_ctrl !== 16'h0000) $display("FAIL mid_rst_ctrl got %0h want 0", bus.out_ctrl); else n_pass++;
    n_total++; if (occupancy !== 2'd0) $display("FAIL mid_rst_occ got %0d want 0", occupancy); else n_pass++;
    n_total++; if (stall_cnt !== 4'd0) $display("FAIL mid_rst_stall got %0d want 0", stall_cnt); else n_pass++;
    send(1'b0, 0, 16'h0);
    #1 rst = 1'b0;
    #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL mid_rst_in_ready got %0b want 1", bus.in_ready); else n_pass++;
    step();
  endtask

  task automatic test_streaming();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      send(1'b1, k, 16'(k + 'h100));
      step();
      n_total++; if (bus.out_data !== DATA_W'(k)) $display("FAIL stream_data[%0d] got %0h want %0h", k, bus.out_data, k); else n_pass++;
      n_total++; if (bus.out_ctrl !== 16'(k + 'h100)) $display("FAIL stream_ctrl[%0d] got %0h want %0h", k, bus.out_ctrl, k + 'h100); else n_pass++;
      n_total++; if (occupancy !== 2'd1 || bus.out_valid !== 1'b1) $display("FAIL stream_occ[%0d] got %0d/%0b want 1/1", k, occupancy, bus.out_valid); else n_pass++;
    end
    send(1'b0, 0, 16'h0);
    step();
    n_total++; if (bus.out_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL stream_drain got %0b/%0d want 0/0", bus.out_valid, occupancy); else n_pass++;
    n_total++; if (stall_cnt !== 4'd0) $display("FAIL stream_stall got %0d want 0", stall_cnt); else n_pass++;
  endtask

  task automatic test_back_pressure();
    bus.out_ready = 1'b0;
    send(1'b1, 32'hA, 16'h000A); step();
    n_total++; if (occupancy !== 2'd1 || bus.out_data !== DATA_W'(32'hA)) $display("FAIL bp_a got occ %0d data %0h want 1 a", occupancy, bus.out_data); else n_pass++;
    send(1'b1, 32'hB, 16'h000B); step();
    n_total++; if (occupancy !== 2'd2 || bus.in_ready !== 1'b0) $display("FAIL bp_two got occ %0d rdy %0b want 2 0", occupancy, bus.in_ready); else n_pass++;
    send(1'b1, 32'hC, 16'h000C); step(); step();
    n_total++; if (bus.out_data !== DATA_W'(32'hA) || occupancy !== 2'd2) $display("FAIL bp_hold got data %0h occ %0d want a 2", bus.out_data, occupancy); else n_pass++;
    n_total++; if (stall_cnt !== 4'd3) $display("FAIL bp_stall got %0d want 3", stall_cnt); else n_pass++;
    bus.out_ready = 1'b1;
    step();
    n_total++; if (bus.out_data !== DATA_W'(32'hB) || bus.out_ctrl !== 16'h000B || occupancy !== 2'd1) $display("FAIL bp_b got data %0h occ %0d want b 1", bus.out_data, occupancy); else n_pass++;
    step();
    n_total++; if (bus.out_data !== DATA_W'(32'hC) || occupancy !== 2'd1) $display("FAIL bp_c got data %0h occ %0d want c 1", bus.out_data, occupancy); else n_pass++;
    send(1'b0, 0, 16'h0); step();
    n_total++; if (bus.out_valid !== 1'b0 || stall_cnt !== 4'd3) $display("FAIL bp_end got valid %0b stall %0d want 0 3", bus.out_valid, stall_cnt); else n_pass++;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    send(1'b1, 32'h11, 16'h0011); step();
    send(1'b1, 32'h22, 16'h0022); step();
    send(1'b1, 32'hEE, 16'h00EE); flush = 1'b1; step();
    flush = 1'b0;
    n_total++; if (occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_ctrl !== 16'h0000) $display("FAIL flush_two got occ %0d valid %0b ctrl %0h want 0 0 0", occupancy, bus.out_valid, bus.out_ctrl); else n_pass++;
    n_total++; if (stall_cnt !== 4'd4) $display("FAIL flush_keeps_stall got %0d want 4", stall_cnt); else n_pass++;
    // From ONE, a flush-cycle input must be discarded.
    send(1'b1, 32'h33, 16'h0033); step();
    send(1'b1, 32'hFF, 16'h00FF); flush = 1'b1; bus.out_ready = 1'b1; step();
    flush = 1'b0; send(1'b0, 0, 16'h0); step();
    n_total++; if (bus.out_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL flush_drop got valid %0b occ %0d want 0 0", bus.out_valid, occupancy); else n_pass++;
    stall_cnt_clr = 1'b1; step(); stall_cnt_clr = 1'b0;
    n_total++; if (stall_cnt !== 4'd0) $display("FAIL clr got %0d want 0", stall_cnt); else n_pass++;
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b0;
    send(1'b1, 32'h55, 16'h0055); step();
    send(1'b0, 0, 16'h0);
    for (int i = 0; i < 20; i++) step();
    n_total++; if (stall_cnt !== 4'd15) $display("FAIL sat got %0d want 15", stall_cnt); else n_pass++;
    stall_cnt_clr = 1'b1; step(); stall_cnt_clr = 1'b0;
    n_total++; if (stall_cnt !== 4'd0) $display("FAIL sat_clr got %0d want 0", stall_cnt); else n_pass++;
    step();
    n_total++; if (stall_cnt !== 4'd1) $display("FAIL sat_resume got %0d want 1", stall_cnt); else n_pass++;
    bus.out_ready = 1'b1; step();
  endtask

  task automatic test_bubble_ctrl();
    bus.out_ready = 1'b1;
    send(1'b1, 32'h77, 16'hFFFF); step();
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== 16'hFFFF) $display("FAIL bub_valid got %0b %0h want 1 ffff", bus.out_valid, bus.out_ctrl); else n_pass++;
    send(1'b0, 0, 16'h0); step();
    n_total++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 16'h0000) $display("FAIL bub_empty got %0b %0h want 0 0", bus.out_valid, bus.out_ctrl); else n_pass++;
    n_total++; if (bus.out_data !== DATA_W'(32'h77)) $display("FAIL bub_data_held got %0h want 77", bus.out_data); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_saturation();
    test_bubble_ctrl();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
